// File: rtl/scr1_dp_mem_init.sv
// scr1_dp_mem_init: dual-port RAM (A read-only, B read/write with byte enables) with zero-fill after reset
// Ports:
//   clk, rst                              clock, synchronous active-high reset
//   rena, addra -> qa, qa_vld             port A read request / data / valid
//   renb, wenb, webb, addrb, datab        port B read and byte-enabled write request
//   qb, qb_vld                            port B read data / valid
//   init_busy                             high while the array is being zero-filled
module scr1_dp_mem_init #(
    parameter int  SCR1_WIDTH   = 32,
    parameter int  SCR1_SIZE    = 65536,
    parameter int  SCR1_RD_LAT  = 1,
    parameter int  SCR1_INIT_EN = 1,
    localparam int NB           = SCR1_WIDTH / 8,
    localparam int DEPTH        = SCR1_SIZE / NB,
    localparam int AW           = $clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  rena,
    input  logic [AW-1:0]         addra,
    output logic [SCR1_WIDTH-1:0] qa,
    output logic                  qa_vld,
    input  logic                  renb,
    input  logic                  wenb,
    input  logic [NB-1:0]         webb,
    input  logic [AW-1:0]         addrb,
    input  logic [SCR1_WIDTH-1:0] datab,
    output logic [SCR1_WIDTH-1:0] qb,
    output logic                  qb_vld,
    output logic                  init_busy
);
    typedef enum logic {INIT, READY} state_t;

    state_t                state, state_nx;
    logic [AW-1:0]         init_cnt;
    logic [SCR1_WIDTH-1:0] mem [DEPTH];
    logic                  busy, acc_a, acc_b;
    logic [NB-1:0]         we;
    logic [AW-1:0]         wadr;
    logic [SCR1_WIDTH-1:0] wdat, rda, rdb, old_b;

    // Zero-fill and port B writes share the single array write port; the
    // fill owns it while busy, and nothing is written during reset.
    always_comb begin
        busy     = state == INIT;
        state_nx = (busy && init_cnt == AW'(DEPTH - 1)) ? READY : state;
        we       = rst ? '0 : busy ? '1 : wenb ? webb : '0;
        wadr     = busy ? init_cnt : addrb;
        wdat     = busy ? '0 : datab;
        acc_a    = rena && !busy;
        acc_b    = renb && !busy;
        rda      = mem[addra];
        old_b    = mem[addrb];
        rdb      = old_b;
        for (int i = 0; i < NB; i++)
            rdb[i*8 +: 8] = (wenb && webb[i]) ? datab[i*8 +: 8] : old_b[i*8 +: 8];
    end

    assign init_busy = rst ? (SCR1_INIT_EN != 0) : busy;

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= (SCR1_INIT_EN != 0) ? INIT : READY;
            init_cnt <= '0;
        end else begin
            state    <= state_nx;
            init_cnt <= busy ? init_cnt + 1'b1 : init_cnt;
        end
    end

    always_ff @(posedge clk)
        for (int i = 0; i < NB; i++)
            if (we[i])
                mem[wadr][i*8 +: 8] <= wdat[i*8 +: 8];

    // Read pipeline: element 0 of the *_c vectors is the stage input, the
    // last register stage is the output. Data registers load only with a
    // valid, so the outputs hold their last value between reads.
    logic [SCR1_RD_LAT:0]   va_c, vb_c;
    logic [SCR1_RD_LAT-1:0] va, vb;
    logic [SCR1_WIDTH-1:0]  da_c [SCR1_RD_LAT+1];
    logic [SCR1_WIDTH-1:0]  db_c [SCR1_RD_LAT+1];
    logic [SCR1_WIDTH-1:0]  da   [SCR1_RD_LAT];
    logic [SCR1_WIDTH-1:0]  db   [SCR1_RD_LAT];

    assign va_c = {va, acc_a};
    assign vb_c = {vb, acc_b};

    always_comb begin
        da_c[0] = rda;
        db_c[0] = rdb;
        for (int k = 0; k < SCR1_RD_LAT; k++) begin
            da_c[k+1] = da[k];
            db_c[k+1] = db[k];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            va <= '0;
            vb <= '0;
            for (int k = 0; k < SCR1_RD_LAT; k++) begin
                da[k] <= '0;
                db[k] <= '0;
            end
        end else begin
            va <= va_c[SCR1_RD_LAT-1:0];
            vb <= vb_c[SCR1_RD_LAT-1:0];
            for (int k = 0; k < SCR1_RD_LAT; k++) begin
                if (va_c[k])
                    da[k] <= da_c[k];
                if (vb_c[k])
                    db[k] <= db_c[k];
            end
        end
    end

    assign qa     = da[SCR1_RD_LAT-1];
    assign qb     = db[SCR1_RD_LAT-1];
    assign qa_vld = va[SCR1_RD_LAT-1];
    assign qb_vld = vb[SCR1_RD_LAT-1];
endmodule
